// File: rtl/game_pkg.sv
// Shared game-state codes and bus widths for the game sequencer, ball datapath and display.
package game_pkg;

    localparam int STATE_W  = 3;
    localparam int LEVEL_W  = 3;
    localparam int PERIOD_W = 20;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [STATE_W-1:0] ST_SERVE = 3'd2;
    localparam logic [STATE_W-1:0] ST_PLAY  = 3'd3;
    localparam logic [STATE_W-1:0] ST_LOST  = 3'd4;
    localparam logic [STATE_W-1:0] ST_WON   = 3'd5;
    localparam logic [STATE_W-1:0] ST_OVER  = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_SERVE = ST_SERVE,
        S_PLAY  = ST_PLAY,
        S_LOST  = ST_LOST,
        S_WON   = ST_WON,
        S_OVER  = ST_OVER
    } state_t;

endpackage

// File: rtl/game_ctrl_if.sv
// Button, datapath-flag and game-status bundle between the sequencer and the ball datapath.
interface game_ctrl_if;
    import game_pkg::*;

    logic                btn_start;
    logic                btn_launch;
    logic                btn_dir;
    logic                dead;
    logic                win;
    logic [STATE_W-1:0]  state;
    logic [LEVEL_W-1:0]  level;
    logic [PERIOD_W-1:0] period;
    logic [2:0]          angle;
    logic [3:0]          lives;
    logic                victory;

    modport master (
        input  btn_start, btn_launch, btn_dir, dead, win,
        output state, level, period, angle, lives, victory
    );

    modport slave (
        output btn_start, btn_launch, btn_dir, dead, win,
        input  state, level, period, angle, lives, victory
    );

endinterface

// File: rtl/game_ctrl_edge_detect.sv
// Registered one-cycle rising-edge pulse; previous value resets high so a button held through reset is ignored.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev  <= 1'b1;
            pulse <= 1'b0;
        end else begin
            prev  <= din;
            pulse <= din & ~prev;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: lives, level progression, pause timing and game over for the ball datapath.
// state | meaning
// IDLE  | waiting for first start press
// LOAD  | one cycle, datapath loads bricks for current level
// SERVE | aiming, dir toggles angle, launch starts ball
// PLAY  | ball running, watch dead/win
// LOST  | pause after a lost ball, life already taken
// WON   | pause after clearing a level
// OVER  | game finished, start begins a new game
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int MAX_LEVEL   = 2,
    parameter int BASE_PERIOD = 500000,
    parameter int PERIOD_STEP = 100000,
    parameter int MIN_PERIOD  = 100000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    game_ctrl_if.master bus
);

    localparam int TIMER_W = $clog2(HOLD_CYCLES);

    state_t              state_q;
    logic [LEVEL_W-1:0]  level_q;
    logic [PERIOD_W-1:0] period_q;
    logic [2:0]          angle_q;
    logic [3:0]          lives_q;
    logic                victory_q;
    logic [TIMER_W-1:0]  timer_q;
    logic                start_p;
    logic                launch_p;
    logic                dir_p;
    logic                hold_done;

    // Signed 24-bit difference so a level past the floor clamps instead of wrapping.
    function automatic logic [PERIOD_W-1:0] calc_period(input logic [LEVEL_W-1:0] lvl);
        logic signed [23:0] diff;
        diff = 24'(BASE_PERIOD) - 24'(PERIOD_STEP * int'(lvl));
        if (diff < $signed(24'(MIN_PERIOD)))
            return PERIOD_W'(MIN_PERIOD);
        return PERIOD_W'(diff);
    endfunction

    edge_detect u_start  (.clk(clk), .rst(rst), .din(bus.btn_start),  .pulse(start_p));
    edge_detect u_launch (.clk(clk), .rst(rst), .din(bus.btn_launch), .pulse(launch_p));
    edge_detect u_dir    (.clk(clk), .rst(rst), .din(bus.btn_dir),    .pulse(dir_p));

    assign hold_done = (timer_q == TIMER_W'(HOLD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            level_q   <= '0;
            period_q  <= PERIOD_W'(BASE_PERIOD);
            angle_q   <= '0;
            lives_q   <= 4'(LIVES);
            victory_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_p)
                        state_q <= S_LOAD;
                end
                S_LOAD: begin
                    state_q <= S_SERVE;
                end
                S_SERVE: begin
                    if (launch_p)
                        state_q <= S_PLAY;
                    else if (dir_p)
                        angle_q <= (angle_q == 3'd0) ? 3'd1 : 3'd0;
                end
                S_PLAY: begin
                    if (bus.win) begin
                        state_q <= S_WON;
                        timer_q <= '0;
                    end else if (bus.dead) begin
                        state_q <= S_LOST;
                        timer_q <= '0;
                        lives_q <= (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
                    end
                end
                S_LOST: begin
                    if (hold_done) begin
                        if (lives_q == 4'd0) begin
                            state_q   <= S_OVER;
                            victory_q <= 1'b0;
                        end else begin
                            state_q <= S_SERVE;
                        end
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                S_WON: begin
                    if (hold_done) begin
                        if (level_q == LEVEL_W'(MAX_LEVEL)) begin
                            state_q   <= S_OVER;
                            victory_q <= 1'b1;
                        end else begin
                            state_q  <= S_LOAD;
                            level_q  <= level_q + 3'd1;
                            period_q <= calc_period(level_q + 3'd1);
                        end
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                S_OVER: begin
                    if (start_p) begin
                        state_q   <= S_LOAD;
                        level_q   <= '0;
                        lives_q   <= 4'(LIVES);
                        victory_q <= 1'b0;
                        period_q  <= PERIOD_W'(BASE_PERIOD);
                        angle_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.level   = level_q;
    assign bus.period  = period_q;
    assign bus.angle   = angle_q;
    assign bus.lives   = lives_q;
    assign bus.victory = victory_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl with an 8-cycle pause: expectations queued with stimulus, drained after each edge.
module tb_game_ctrl;

    localparam int HOLD = 8;

    localparam int F_STATE   = 0;
    localparam int F_LEVEL   = 1;
    localparam int F_PERIOD  = 2;
    localparam int F_ANGLE   = 3;
    localparam int F_LIVES   = 4;
    localparam int F_VICTORY = 5;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    string q_tag[$];
    int    q_fld[$];
    int    q_val[$];

    game_ctrl_if bus();

    game_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int read_field(input int fld);
        case (fld)
            F_STATE:   return int'(bus.state);
            F_LEVEL:   return int'(bus.level);
            F_PERIOD:  return int'(bus.period);
            F_ANGLE:   return int'(bus.angle);
            F_LIVES:   return int'(bus.lives);
            default:   return int'(bus.victory);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int fld, input int val);
        q_tag.push_back(tag);
        q_fld.push_back(fld);
        q_val.push_back(val);
    endtask

    task automatic step();
        string t;
        int    f;
        int    v;
        @(posedge clk);
        #1;
        while (q_tag.size() > 0) begin
            t = q_tag.pop_front();
            f = q_fld.pop_front();
            v = q_val.pop_front();
            check_val(t, read_field(f), v);
        end
    endtask

    // which: 0 start, 1 launch, 2 dir; button high for exactly one edge
    task automatic press(input int which);
        case (which)
            0: bus.btn_start  = 1'b1;
            1: bus.btn_launch = 1'b1;
            default: bus.btn_dir = 1'b1;
        endcase
        step();
        bus.btn_start  = 1'b0;
        bus.btn_launch = 1'b0;
        bus.btn_dir    = 1'b0;
    endtask

    task automatic hold_phase(input string tag, input int st);
        for (int i = 0; i < HOLD - 1; i++) begin
            expect_val(tag, F_STATE, st);
            step();
        end
    endtask

    task automatic lose_ball(input int lives_after, input int exit_state);
        press(1);
        expect_val("play_enter", F_STATE, 3);
        step();
        bus.dead = 1'b1;
        expect_val("lost_enter", F_STATE, 4);
        expect_val("lost_lives", F_LIVES, lives_after);
        step();
        hold_phase("lost_hold", 4);
        expect_val("lost_exit", F_STATE, exit_state);
        step();
        bus.dead = 1'b0;
    endtask

    task automatic win_level(input int next_state, input int next_level, input int next_period);
        press(1);
        expect_val("play_enter", F_STATE, 3);
        step();
        bus.win = 1'b1;
        expect_val("won_enter", F_STATE, 5);
        step();
        hold_phase("won_hold", 5);
        expect_val("won_exit", F_STATE, next_state);
        expect_val("won_level", F_LEVEL, next_level);
        expect_val("won_period", F_PERIOD, next_period);
        expect_val("won_lives", F_LIVES, 3);
        step();
        bus.win = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.btn_start  = 1'b0;
        bus.btn_launch = 1'b0;
        bus.btn_dir    = 1'b0;
        bus.dead       = 1'b0;
        bus.win        = 1'b0;
        step();
        expect_val("rst_state",   F_STATE,   0);
        expect_val("rst_level",   F_LEVEL,   0);
        expect_val("rst_period",  F_PERIOD,  500000);
        expect_val("rst_angle",   F_ANGLE,   0);
        expect_val("rst_lives",   F_LIVES,   3);
        expect_val("rst_victory", F_VICTORY, 0);
        step();
        rst = 1'b1;
        step();

        // start held three cycles: one LOAD only
        bus.btn_start = 1'b1;
        expect_val("start_pulse_idle", F_STATE, 0);
        step();
        expect_val("load_state",  F_STATE,  1);
        expect_val("load_level",  F_LEVEL,  0);
        expect_val("load_period", F_PERIOD, 500000);
        expect_val("load_lives",  F_LIVES,  3);
        step();
        expect_val("serve_state", F_STATE, 2);
        step();
        bus.btn_start = 1'b0;
        expect_val("serve_stay", F_STATE, 2);
        step();

        // aim, launch, dir ignored in PLAY
        press(2);
        expect_val("dir_toggle", F_ANGLE, 1);
        expect_val("dir_state", F_STATE, 2);
        step();
        press(1);
        expect_val("launch_state", F_STATE, 3);
        step();
        press(2);
        expect_val("play_angle_frozen", F_ANGLE, 1);
        expect_val("play_stay", F_STATE, 3);
        step();

        // first loss, then launch+dir together
        bus.dead = 1'b1;
        expect_val("lost1_state", F_STATE, 4);
        expect_val("lost1_lives", F_LIVES, 2);
        step();
        hold_phase("lost1_hold", 4);
        expect_val("lost1_exit", F_STATE, 2);
        step();
        bus.dead = 1'b0;
        bus.btn_dir = 1'b1;
        press(1);
        expect_val("launch_dir_state", F_STATE, 3);
        expect_val("launch_dir_angle", F_ANGLE, 1);
        step();
        bus.dead = 1'b1;
        expect_val("lost2_state", F_STATE, 4);
        expect_val("lost2_lives", F_LIVES, 1);
        step();
        hold_phase("lost2_hold", 4);
        expect_val("lost2_exit", F_STATE, 2);
        step();
        bus.dead = 1'b0;
        lose_ball(0, 6);
        expect_val("over_victory", F_VICTORY, 0);
        expect_val("over_hold", F_STATE, 6);
        step();

        // restart from OVER
        press(0);
        expect_val("restart_state", F_STATE, 1);
        expect_val("restart_lives", F_LIVES, 3);
        expect_val("restart_angle", F_ANGLE, 0);
        step();
        expect_val("restart_serve", F_STATE, 2);
        step();

        // win with dead in the same cycle, levels 0 -> 1 -> 2
        press(1);
        expect_val("play_l0", F_STATE, 3);
        step();
        bus.win  = 1'b1;
        bus.dead = 1'b1;
        expect_val("win_prio_state", F_STATE, 5);
        expect_val("win_prio_lives", F_LIVES, 3);
        step();
        hold_phase("won0_hold", 5);
        expect_val("won0_exit",   F_STATE,  1);
        expect_val("won0_level",  F_LEVEL,  1);
        expect_val("won0_period", F_PERIOD, 400000);
        expect_val("won0_lives",  F_LIVES,  3);
        step();
        bus.win  = 1'b0;
        bus.dead = 1'b0;
        expect_val("l1_serve", F_STATE, 2);
        step();
        win_level(1, 2, 300000);
        expect_val("l2_serve", F_STATE, 2);
        step();
        win_level(6, 2, 300000);
        expect_val("final_victory", F_VICTORY, 1);
        step();
        press(0);
        expect_val("new_game_state",   F_STATE,   1);
        expect_val("new_game_level",   F_LEVEL,   0);
        expect_val("new_game_lives",   F_LIVES,   3);
        expect_val("new_game_victory", F_VICTORY, 0);
        expect_val("new_game_period",  F_PERIOD,  500000);
        step();
        expect_val("new_game_serve", F_STATE, 2);
        step();

        // reset mid-pause with start held through it
        press(1);
        expect_val("play_pre_rst", F_STATE, 3);
        step();
        bus.dead = 1'b1;
        expect_val("lost_pre_rst", F_STATE, 4);
        step();
        for (int i = 0; i < 4; i++) begin
            expect_val("lost_wait_rst", F_STATE, 4);
            step();
        end
        rst = 1'b0;
        bus.btn_start = 1'b1;
        expect_val("midrst_state", F_STATE, 0);
        expect_val("midrst_lives", F_LIVES, 3);
        expect_val("midrst_level", F_LEVEL, 0);
        step();
        rst = 1'b1;
        bus.dead = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_val("held_start_no_load", F_STATE, 0);
            step();
        end
        bus.btn_start = 1'b0;
        step();
        press(0);
        expect_val("repress_load", F_STATE, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
